// File: rtl/packed_struct_byte_sched_pkg.sv
// Shared types for the packed-struct byte scheduler.
//   psa_word_t  : 16-bit word, byte1 in [15:8] sent first, byte2 in [7:0] sent second
//   psa_state_e : scheduler FSM states
package psa_pkg;

    localparam int unsigned PSA_WORD_W = 16;
    localparam int unsigned PSA_BYTE_W = 8;

    typedef struct packed {
        logic [PSA_BYTE_W-1:0] byte1;
        logic [PSA_BYTE_W-1:0] byte2;
    } psa_word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_B1 = 2'd1,
        SEND_B2 = 2'd2
    } psa_state_e;

endpackage

// File: rtl/packed_struct_byte_sched_if.sv
// Word-in / byte-out bus of the packed-struct byte scheduler.
//   in_valid/in_ready : per-channel word handshake, in_data channel c at [c*16 +: 16]
//   out_valid/out_ready, out_byte, out_last, out_src : byte stream toward the consumer
// Modports: master = producers/consumer side, slave = scheduler side.
interface packed_struct_byte_sched_if #(
    parameter int unsigned NUM_CH = 2
);
    localparam int unsigned SRC_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]    in_valid;
    logic [NUM_CH*16-1:0] in_data;
    logic [NUM_CH-1:0]    in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_byte;
    logic                 out_last;
    logic [SRC_W-1:0]     out_src;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_byte, out_last, out_src
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_byte, out_last, out_src
    );
endinterface

// File: rtl/packed_struct_byte_sched_arb.sv
// Round-robin arbiter for the byte scheduler.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   req_i          : per-channel request
//   advance_i      : a transfer happened on the granted channel this cycle
//   gnt_oh_o       : one-hot grant (zero when no request)
//   gnt_idx_o      : encoded grant index
//   last_grant_o   : most recently transferred channel (reset NUM_CH-1 so ch0 wins first)
module psa_rr_arbiter #(
    parameter int unsigned NUM_CH = 2,
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              advance_i,
    output logic [NUM_CH-1:0] gnt_oh_o,
    output logic [IDX_W-1:0]  gnt_idx_o,
    output logic [IDX_W-1:0]  last_grant_o
);

    logic [IDX_W-1:0] last_q;
    logic             found;
    int unsigned      cand;

    // Search last+1, last+2, ... wrapping, first requester wins.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            cand = (32'(last_q) + off) % NUM_CH;
            if (!found && req_i[cand]) begin
                found           = 1'b1;
                gnt_idx_o       = IDX_W'(cand);
                gnt_oh_o[cand]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDX_W'(NUM_CH - 1);
        end else if (advance_i && found) begin
            last_q <= gnt_idx_o;
        end
    end

    assign last_grant_o = last_q;

endmodule

// File: rtl/packed_struct_byte_sched.sv
// Packed-struct byte scheduler: NUM_CH word producers share one byte stream.
// A granted 16-bit word is emitted as byte1 then byte2 (out_last on byte2),
// tagged with the source channel in out_src.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : packed_struct_byte_sched_if slave (word inputs, byte output)
//   busy       : a word is held (FSM not idle)
//   grant_cnt  : per-channel saturating accepted-word counters, channel c at [c*8 +: 8]
// Build option: define PSA_GRANT_CNT_EN to enable grant_cnt; otherwise it is tied to 0.
module packed_struct_byte_sched
    import psa_pkg::*;
#(
    parameter int unsigned NUM_CH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    packed_struct_byte_sched_if.slave   bus,
    output logic                        busy,
    output logic [NUM_CH*8-1:0]         grant_cnt
);

    localparam int unsigned SRC_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    psa_state_e       state_q;
    psa_word_t        word_q;
    logic             out_valid_q;
    logic [7:0]       out_byte_q;
    logic             out_last_q;
    logic [SRC_W-1:0] out_src_q;

    logic [NUM_CH-1:0] gnt_oh;
    logic [SRC_W-1:0]  gnt_idx;
    logic [SRC_W-1:0]  last_grant;
    logic              accept_slot;
    logic              take;
    psa_word_t         new_word;

    // A new word may enter when idle, or as byte2 leaves so words run back-to-back.
    assign accept_slot = (state_q == IDLE) || ((state_q == SEND_B2) && bus.out_ready);
    assign bus.in_ready = accept_slot ? gnt_oh : '0;
    assign take         = accept_slot && (|bus.in_valid);
    assign new_word     = psa_word_t'(bus.in_data[32'(gnt_idx)*PSA_WORD_W +: PSA_WORD_W]);

    psa_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (bus.in_valid),
        .advance_i    (take),
        .gnt_oh_o     (gnt_oh),
        .gnt_idx_o    (gnt_idx),
        .last_grant_o (last_grant)
    );

    // take already folds in the state, so the load path is shared by IDLE and SEND_B2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else if (take) begin
            state_q     <= SEND_B1;
            word_q      <= new_word;
            out_valid_q <= 1'b1;
            out_byte_q  <= new_word.byte1;
            out_last_q  <= 1'b0;
            out_src_q   <= gnt_idx;
        end else begin
            unique case (state_q)
                SEND_B1: begin
                    if (bus.out_ready) begin
                        state_q    <= SEND_B2;
                        out_byte_q <= word_q.byte2;
                        out_last_q <= 1'b1;
                    end
                end
                SEND_B2: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;
    assign busy          = (state_q != IDLE);

`ifdef PSA_GRANT_CNT_EN
    logic [NUM_CH-1:0] xfer;
    logic [7:0]        cnt_q [NUM_CH];

    assign xfer = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (xfer[c] && (cnt_q[c] != 8'hFF)) begin
                    cnt_q[c] <= cnt_q[c] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            grant_cnt[c*8 +: 8] = cnt_q[c];
        end
    end
`else
    assign grant_cnt = '0;
`endif

    // last_grant is held inside the arbiter; exposed only for debug visibility.
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

endmodule

// File: tb/tb_packed_struct_byte_sched.sv
module tb_packed_struct_byte_sched;
    import psa_pkg::*;

    localparam int unsigned NCH = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic [NCH*8-1:0] grant_cnt;

    always #5 clk = ~clk;

    packed_struct_byte_sched_if #(.NUM_CH(NCH)) bus();

    packed_struct_byte_sched #(.NUM_CH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .grant_cnt (grant_cnt)
    );

    int n_checks = 0;
    int n_pass = 0;
    int cyc_n = 0;

    logic [15:0] wq [NCH][$];     // pending words per producer
    logic [10:0] got[$];          // {src[1:0], last, byte} per accepted output byte
    int          got_cyc[$];
    int          acc_ch[$];
    int          acc_cyc[$];
    logic [10:0] exp_q[$];

    bit          hold_prev = 0;
    logic [10:0] prev_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            bus.in_valid[c]        = (wq[c].size() != 0);
            bus.in_data[c*16 +: 16] = (wq[c].size() != 0) ? wq[c][0] : 16'h0;
        end
    endtask

    // One clock: sample mid-cycle, commit handshakes at the edge, redrive 1ns after.
    task automatic cyc();
        logic [NCH-1:0] ir;
        bit             ob;
        logic [10:0]    cur;
        @(negedge clk);
        chk("in_ready_onehot0", 32'($onehot0(bus.in_ready)), 32'd1);
        cur = {bus.out_src, bus.out_last, bus.out_byte};
        if (hold_prev) begin
            chk("out_valid_hold", 32'(bus.out_valid), 32'd1);
            chk("out_stable", 32'(cur), 32'(prev_out));
        end
        ir = bus.in_valid & bus.in_ready;
        ob = bus.out_valid && bus.out_ready;
        hold_prev = bus.out_valid && !bus.out_ready;
        prev_out  = cur;
        @(posedge clk);
        cyc_n++;
        for (int c = 0; c < NCH; c++) begin
            if (ir[c]) begin
                acc_ch.push_back(c);
                acc_cyc.push_back(cyc_n);
                void'(wq[c].pop_front());
            end
        end
        if (ob) begin
            got.push_back(cur);
            got_cyc.push_back(cyc_n);
        end
        #1 drive();
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k = 0;
        while (got.size() < n && k < budget) begin
            cyc();
            k++;
        end
        chk(tag, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic clear_all();
        for (int c = 0; c < NCH; c++) wq[c].delete();
        got.delete(); got_cyc.delete(); acc_ch.delete(); acc_cyc.delete(); exp_q.delete();
        hold_prev = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_all();
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference: with every producer holding its words from the start, the output
    // is a round-robin interleave of the queues beginning at channel 0.
    task automatic build_expected();
        logic [15:0] q [NCH][$];
        int last = NCH - 1;
        bool_loop: for (int c = 0; c < NCH; c++) q[c] = wq[c];
        exp_q.delete();
        forever begin
            int pick = -1;
            for (int off = 1; off <= NCH; off++) begin
                int c = (last + off) % NCH;
                if (pick < 0 && q[c].size() != 0) pick = c;
            end
            if (pick < 0) break;
            exp_q.push_back({2'(pick), 1'b0, q[pick][0][15:8]});
            exp_q.push_back({2'(pick), 1'b1, q[pick][0][7:0]});
            void'(q[pick].pop_front());
            last = pick;
        end
    endtask

    initial begin
        int t0;
        int errs;
        logic [7:0] exp_cnt;

        bus.out_ready = 1'b0;
        clear_all();
        drive();

        // Reset values
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_byte", 32'(bus.out_byte), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_src", 32'(bus.out_src), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_grant_cnt", 32'(grant_cnt), 32'd0);
        do_reset();

        // 1. Single word on ch0
        bus.out_ready = 1'b1;
        wq[0].push_back(16'hA55A);
        drive();
        run_until(2, 20, "t1_timeout");
        chk("t1_acc_ch", 32'(acc_ch[0]), 32'd0);
        chk("t1_byte1", 32'(got[0]), {21'd0, 2'd0, 1'b0, 8'hA5});
        chk("t1_byte2", 32'(got[1]), {21'd0, 2'd0, 1'b1, 8'h5A});
        chk("t1_latency", 32'(got_cyc[0] - acc_cyc[0]), 32'd1);
        chk("t1_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // 2. Contention ch0/ch1, no gaps
        do_reset();
        bus.out_ready = 1'b1;
        wq[0] = '{16'h1122, 16'h0102};
        wq[1] = '{16'h3344, 16'h0304};
        drive();
        build_expected();
        run_until(8, 40, "t2_timeout");
        for (int i = 0; i < 4; i++) chk("t2_grant_order", 32'(acc_ch[i]), 32'(i % 2));
        for (int i = 0; i < 8; i++) chk("t2_stream", 32'(got[i]), 32'(exp_q[i]));
        chk("t2_stream_0", 32'(got[0][7:0]), 32'h11);
        chk("t2_stream_3", 32'(got[3][7:0]), 32'h44);
        chk("t2_no_gap", 32'(got_cyc[7] - got_cyc[0]), 32'd7);

        // 3. Backpressure during byte1
        do_reset();
        bus.out_ready = 1'b0;
        wq[0] = '{16'h1122};
        wq[1] = '{16'h3344};
        drive();
        t0 = 0;
        while (!bus.out_valid && t0 < 10) begin cyc(); t0++; end
        chk("t3_valid_timeout", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_byte", 32'(bus.out_byte), 32'h11);
            chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
            cyc();
        end
        chk("t3_ch1_pending", 32'(wq[1].size()), 32'd1);
        bus.out_ready = 1'b1;
        run_until(4, 20, "t3_timeout");
        chk("t3_b0", 32'(got[0][7:0]), 32'h11);
        chk("t3_b1", 32'(got[1][7:0]), 32'h22);
        chk("t3_b2", 32'(got[2][7:0]), 32'h33);
        chk("t3_b3", 32'(got[3][7:0]), 32'h44);

        // 4. Reset while in SEND_B2
        do_reset();
        bus.out_ready = 1'b1;
        wq[1] = '{16'hABCD};
        drive();
        t0 = 0;
        while (!(bus.out_valid && bus.out_last) && t0 < 10) begin cyc(); t0++; end
        chk("t4_reach_b2", 32'(bus.out_last), 32'd1);
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_async_busy", 32'(busy), 32'd0);
        chk("t4_async_last", 32'(bus.out_last), 32'd0);
        do_reset();
        bus.out_ready = 1'b1;
        wq[0] = '{16'h1234};
        wq[1] = '{16'h5678};
        drive();
        run_until(4, 20, "t4_timeout");
        chk("t4_first_src", 32'(got[0]), {21'd0, 2'd0, 1'b0, 8'h12});
        chk("t4_second_src", 32'(got[2]), {21'd0, 2'd1, 1'b0, 8'h56});

        // 5. 300 words on ch1, counter saturation
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 300; i++) wq[1].push_back(16'(i * 7 + 3));
        drive();
        build_expected();
        run_until(600, 1500, "t5_timeout");
        errs = 0;
        for (int i = 0; i < 600 && i < got.size(); i++) if (got[i] !== exp_q[i]) errs++;
        chk("t5_stream_errs", 32'(errs), 32'd0);
`ifdef PSA_GRANT_CNT_EN
        exp_cnt = 8'hFF;
`else
        exp_cnt = 8'h00;
`endif
        chk("t5_cnt_ch1", 32'(grant_cnt[15:8]), 32'(exp_cnt));
        chk("t5_cnt_ch0", 32'(grant_cnt[7:0]), 32'd0);
        chk("t5_cnt_ch2", 32'(grant_cnt[23:16]), 32'd0);

        // Randomised rounds: random word counts, random backpressure
        for (int r = 0; r < 4; r++) begin
            int k;
            do_reset();
            for (int c = 0; c < NCH; c++) begin
                int n = $urandom_range(0, 10);
                for (int i = 0; i < n; i++) wq[c].push_back(16'($urandom));
            end
            drive();
            build_expected();
            k = 0;
            while (got.size() < exp_q.size() && k < 500) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                cyc();
                k++;
            end
            chk("rnd_count", 32'(got.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got.size(); i++)
                chk("rnd_byte", 32'(got[i]), 32'(exp_q[i]));
            bus.out_ready = 1'b1;
            cyc();
            chk("rnd_idle_busy", 32'(busy), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
